// File: rtl/spi_cmd_regfile.sv
// spi_cmd_regfile: command interpreter and configuration register bank fed by
// the SPI deserializer. A command byte (bit 7 = write, bits 6:0 = start
// address) opens a burst of auto-incrementing writes or reads that lasts until
// frame_end. Read results go to the parallel-to-serial return path.
module spi_cmd_regfile #(
  parameter int NUM_REGS = 16,
  parameter int ADDR_W   = 7
) (
  input  logic                  iclk,
  input  logic                  rst,
  input  logic [7:0]            byte_in,
  input  logic                  byte_valid,
  input  logic                  frame_end,
  input  logic                  err_clr,
  output logic [NUM_REGS*8-1:0] regs_out,
  output logic                  wr_strobe,
  output logic [ADDR_W-1:0]     wr_addr,
  output logic [7:0]            rd_data,
  output logic                  rd_valid,
  output logic                  busy,
  output logic                  err
);

  typedef enum logic [1:0] {IDLE, WRITE, READ} state_t;

  state_t                state;
  state_t                next_state;
  logic [ADDR_W-1:0]     ptr;
  logic [ADDR_W-1:0]     cmd_addr;
  logic [ADDR_W-1:0]     acc_addr;
  logic                  acc_hit;
  logic [7:0]            acc_rdata;
  logic [NUM_REGS*8-1:0] regs_q;

  assign cmd_addr = ADDR_W'(byte_in[6:0]);
  assign regs_out = regs_q;

  // Decode the address the current byte targets, its lookup, and the next state.
  always_comb begin
    // NOTE: every combinational output gets a default first so no path
    // leaves it unassigned, which would infer a latch.
    next_state = state;
    acc_addr   = ptr;
    acc_hit    = 1'b0;
    acc_rdata  = 8'h00;
    if (byte_valid) begin
      case (state)
        IDLE: begin
          acc_addr   = cmd_addr;
          next_state = byte_in[7] ? WRITE : READ;
        end
        WRITE:   acc_addr = ptr;
        READ:    acc_addr = ptr + ADDR_W'(1);
        default: acc_addr = ptr;
      endcase
    end
    // A byte arriving with frame_end is still processed above; the frame closes after it.
    if (frame_end) next_state = IDLE;
    // Out-of-range addresses match no register and leave acc_hit low.
    for (int k = 0; k < NUM_REGS; k++) begin
      if (acc_addr == ADDR_W'(k)) begin
        acc_hit   = 1'b1;
        acc_rdata = regs_q[k*8 +: 8];
      end
    end
  end

  // FSM, address pointer, register bank and registered pulse/status outputs.
  always_ff @(posedge iclk) begin
    if (rst) begin
      // NOTE: the bank is reset in full because these registers drive analog
      // and digital controls that must come up in a known state.
      state     <= IDLE;
      ptr       <= '0;
      regs_q    <= '0;
      wr_strobe <= 1'b0;
      wr_addr   <= '0;
      rd_data   <= 8'h00;
      rd_valid  <= 1'b0;
      busy      <= 1'b0;
      err       <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments throughout, so later lines (err set
      // after err_clr) override earlier ones within the same edge.
      state     <= next_state;
      busy      <= (next_state != IDLE);
      wr_strobe <= 1'b0;
      rd_valid  <= 1'b0;
      if (err_clr) err <= 1'b0;
      if (byte_valid) begin
        case (state)
          IDLE: begin
            ptr <= cmd_addr;
            if (!byte_in[7]) begin
              rd_valid <= 1'b1;
              rd_data  <= acc_rdata;
              if (!acc_hit) err <= 1'b1;
            end
          end
          WRITE: begin
            if (acc_hit) begin
              for (int k = 0; k < NUM_REGS; k++) begin
                if (ptr == ADDR_W'(k)) regs_q[k*8 +: 8] <= byte_in;
              end
              wr_strobe <= 1'b1;
              wr_addr   <= ptr;
            end else begin
              err <= 1'b1;
            end
            ptr <= ptr + ADDR_W'(1);
          end
          READ: begin
            ptr      <= acc_addr;
            rd_valid <= 1'b1;
            rd_data  <= acc_rdata;
            if (!acc_hit) err <= 1'b1;
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_spi_cmd_regfile.sv
// Directed bench for spi_cmd_regfile: a table of per-cycle stimulus with
// hand-computed outputs, followed by hand-written reset and bank-content checks.
module tb_spi_cmd_regfile;

  localparam int NUM_REGS = 16;
  localparam int ADDR_W   = 7;

  logic                  iclk = 1'b0;
  logic                  rst;
  logic [7:0]            byte_in;
  logic                  byte_valid;
  logic                  frame_end;
  logic                  err_clr;
  logic [NUM_REGS*8-1:0] regs_out;
  logic                  wr_strobe;
  logic [ADDR_W-1:0]     wr_addr;
  logic [7:0]            rd_data;
  logic                  rd_valid;
  logic                  busy;
  logic                  err;

  int checks   = 0;
  int failures = 0;

  spi_cmd_regfile #(.NUM_REGS(NUM_REGS), .ADDR_W(ADDR_W)) dut (
    .iclk       (iclk),
    .rst        (rst),
    .byte_in    (byte_in),
    .byte_valid (byte_valid),
    .frame_end  (frame_end),
    .err_clr    (err_clr),
    .regs_out   (regs_out),
    .wr_strobe  (wr_strobe),
    .wr_addr    (wr_addr),
    .rd_data    (rd_data),
    .rd_valid   (rd_valid),
    .busy       (busy),
    .err        (err)
  );

  always #5 iclk = ~iclk;

  typedef struct {
    logic       bv;
    logic [7:0] din;
    logic       fe;
    logic       clr;
    logic       ws;
    logic [6:0] wa;
    logic       rv;
    logic [7:0] rd;
    logic       bsy;
    logic       er;
  } vec_t;

  vec_t vecs[$];

  task automatic check(input string name, input logic [127:0] actual, input logic [127:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, actual, expected);
    end
  endtask

  // Inputs set before this call are sampled at the next rising edge; outputs
  // are inspected 1 time unit after it.
  task automatic tick();
    @(posedge iclk);
    #1;
  endtask

  function automatic vec_t mk(logic bv, logic [7:0] din, logic fe, logic clr,
                              logic ws, logic [6:0] wa, logic rv, logic [7:0] rd,
                              logic bsy, logic er);
    vec_t v;
    v.bv = bv; v.din = din; v.fe = fe; v.clr = clr;
    v.ws = ws; v.wa = wa; v.rv = rv; v.rd = rd; v.bsy = bsy; v.er = er;
    return v;
  endfunction

  task automatic drive(logic bv, logic [7:0] din, logic fe, logic clr);
    byte_valid = bv;
    byte_in    = din;
    frame_end  = fe;
    err_clr    = clr;
  endtask

  logic [NUM_REGS*8-1:0] exp_regs;

  initial begin
    rst = 1'b1;
    drive(1'b0, 8'h00, 1'b0, 1'b0);
    tick();
    tick();
    check("reset regs_out", regs_out, '0);
    check("reset wr_strobe", wr_strobe, 0);
    check("reset wr_addr", wr_addr, 0);
    check("reset rd_data", rd_data, 0);
    check("reset rd_valid", rd_valid, 0);
    check("reset busy", busy, 0);
    check("reset err", err, 0);
    rst = 1'b0;
    tick();

    //            bv  din    fe  clr  ws  wa     rv  rd     bsy er
    vecs.push_back(mk(1, 8'h83, 0, 0,  0, 7'd0,  0, 8'h00, 1, 0)); // write cmd @3
    vecs.push_back(mk(1, 8'hA5, 0, 0,  1, 7'd3,  0, 8'h00, 1, 0)); // reg3=A5
    vecs.push_back(mk(0, 8'h00, 1, 0,  0, 7'd0,  0, 8'h00, 0, 0)); // frame end
    vecs.push_back(mk(1, 8'h8E, 0, 0,  0, 7'd0,  0, 8'h00, 1, 0)); // write cmd @14
    vecs.push_back(mk(1, 8'h11, 0, 0,  1, 7'd14, 0, 8'h00, 1, 0)); // reg14
    vecs.push_back(mk(1, 8'h22, 0, 0,  1, 7'd15, 0, 8'h00, 1, 0)); // reg15 (last)
    vecs.push_back(mk(1, 8'h33, 0, 0,  0, 7'd0,  0, 8'h00, 1, 1)); // addr 16: err
    vecs.push_back(mk(0, 8'h00, 1, 0,  0, 7'd0,  0, 8'h00, 0, 1)); // err sticky
    vecs.push_back(mk(0, 8'h00, 0, 1,  0, 7'd0,  0, 8'h00, 0, 0)); // err_clr
    vecs.push_back(mk(1, 8'h85, 0, 0,  0, 7'd0,  0, 8'h00, 1, 0)); // write cmd @5
    vecs.push_back(mk(1, 8'h5A, 0, 0,  1, 7'd5,  0, 8'h00, 1, 0));
    vecs.push_back(mk(1, 8'h6B, 0, 0,  1, 7'd6,  0, 8'h00, 1, 0));
    vecs.push_back(mk(0, 8'h00, 1, 0,  0, 7'd0,  0, 8'h00, 0, 0));
    vecs.push_back(mk(1, 8'h05, 0, 0,  0, 7'd0,  1, 8'h5A, 1, 0)); // read cmd @5
    vecs.push_back(mk(0, 8'h00, 0, 0,  0, 7'd0,  0, 8'h00, 1, 0)); // gap
    vecs.push_back(mk(1, 8'h00, 0, 0,  0, 7'd0,  1, 8'h6B, 1, 0)); // dummy -> reg6
    vecs.push_back(mk(0, 8'h00, 1, 0,  0, 7'd0,  0, 8'h00, 0, 0));
    vecs.push_back(mk(1, 8'h81, 0, 0,  0, 7'd0,  0, 8'h00, 1, 0)); // write cmd @1
    vecs.push_back(mk(1, 8'h77, 1, 0,  1, 7'd1,  0, 8'h00, 0, 0)); // data + frame end
    vecs.push_back(mk(1, 8'h02, 0, 0,  0, 7'd0,  1, 8'h00, 1, 0)); // read cmd @2
    vecs.push_back(mk(0, 8'h00, 1, 0,  0, 7'd0,  0, 8'h00, 0, 0));
    vecs.push_back(mk(1, 8'hFF, 0, 0,  0, 7'd0,  0, 8'h00, 1, 0)); // write cmd @127
    vecs.push_back(mk(1, 8'h01, 0, 0,  0, 7'd0,  0, 8'h00, 1, 1)); // 127: err
    vecs.push_back(mk(1, 8'h02, 0, 0,  1, 7'd0,  0, 8'h00, 1, 1)); // wrapped: reg0
    vecs.push_back(mk(0, 8'h00, 1, 1,  0, 7'd0,  0, 8'h00, 0, 0)); // end + clear
    vecs.push_back(mk(1, 8'h10, 0, 1,  0, 7'd0,  1, 8'h00, 1, 1)); // OOR read, set wins
    vecs.push_back(mk(0, 8'h00, 1, 1,  0, 7'd0,  0, 8'h00, 0, 0));
    vecs.push_back(mk(1, 8'h0F, 0, 0,  0, 7'd0,  1, 8'h22, 1, 0)); // read reg15
    vecs.push_back(mk(1, 8'h00, 0, 0,  0, 7'd0,  1, 8'h00, 1, 1)); // back-to-back -> 16: err
    vecs.push_back(mk(0, 8'h00, 1, 1,  0, 7'd0,  0, 8'h00, 0, 0));

    foreach (vecs[i]) begin
      drive(vecs[i].bv, vecs[i].din, vecs[i].fe, vecs[i].clr);
      tick();
      check($sformatf("row%0d wr_strobe", i), wr_strobe, vecs[i].ws);
      if (vecs[i].ws) check($sformatf("row%0d wr_addr", i), wr_addr, vecs[i].wa);
      check($sformatf("row%0d rd_valid", i), rd_valid, vecs[i].rv);
      if (vecs[i].rv) check($sformatf("row%0d rd_data", i), rd_data, vecs[i].rd);
      check($sformatf("row%0d busy", i), busy, vecs[i].bsy);
      check($sformatf("row%0d err", i), err, vecs[i].er);
    end
    drive(1'b0, 8'h00, 1'b0, 1'b0);
    tick();

    exp_regs = '0;
    exp_regs[0*8 +: 8]  = 8'h02;
    exp_regs[1*8 +: 8]  = 8'h77;
    exp_regs[3*8 +: 8]  = 8'hA5;
    exp_regs[5*8 +: 8]  = 8'h5A;
    exp_regs[6*8 +: 8]  = 8'h6B;
    exp_regs[14*8 +: 8] = 8'h11;
    exp_regs[15*8 +: 8] = 8'h22;
    check("bank contents", regs_out, exp_regs);

    // Reset between command and data discards the partial frame.
    drive(1'b1, 8'h84, 1'b0, 1'b0);
    tick();
    check("pre-reset busy", busy, 1);
    drive(1'b0, 8'h00, 1'b0, 1'b0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("mid reset busy", busy, 0);
    check("mid reset regs_out", regs_out, '0);
    drive(1'b1, 8'h99, 1'b0, 1'b0);
    tick();
    check("0x99 as cmd wr_strobe", wr_strobe, 0);
    check("0x99 as cmd busy", busy, 1);
    check("0x99 as cmd err", err, 0);
    check("0x99 as cmd regs", regs_out, '0);
    drive(1'b1, 8'h55, 1'b0, 1'b0);
    tick();
    check("OOR data wr_strobe", wr_strobe, 0);
    check("OOR data err", err, 1);
    check("OOR data regs", regs_out, '0);
    drive(1'b0, 8'h00, 1'b1, 1'b0);
    tick();
    check("final busy", busy, 0);
    check("final err sticky", err, 1);
    drive(1'b0, 8'h00, 1'b0, 1'b0);
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
